// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and scan-code decoder.
// Synchronises and filters the PS/2 lines, frames 11-bit PS/2 words, folds the
// E0 (extended) and F0 (break) prefixes into the following code, and queues
// {ext, brk, code} events in a first-word fall-through FIFO.
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          CLK100MHz,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Synchroniser / filter stage
    logic            ps2_clk_p0, ps2_clk_p1;
    logic            ps2_data_p0, ps2_data_p1;
    logic            clk_filt;
    logic [7:0]      filt_cnt;
    logic            fall_evt;
    logic            fall_data;

    // Frame stage
    state_t          state, state_n;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic [TW-1:0]   tmo_cnt;
    logic            timeout;
    logic            par_ok;
    logic            done_c;
    logic            err_c;
`ifdef PS2_PARITY_CHECK_EN
    logic            par_bit;
`endif

    // Decode / push stage
    logic            vld_p1;
    logic [7:0]      byte_p1;
    logic            ext_flag, brk_flag;
    logic            push;

    // FIFO
    logic [9:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            do_pop;
    logic            do_write;
    logic [9:0]      head;

    // Clock-line synchroniser, stability filter and one-cycle falling-edge strobe
    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            ps2_clk_p0 <= 1'b1;
            ps2_clk_p1 <= 1'b1;
            clk_filt   <= 1'b1;
            filt_cnt   <= '0;
            fall_evt   <= 1'b0;
        end else begin
            ps2_clk_p0 <= ps2_clk;
            ps2_clk_p1 <= ps2_clk_p0;
            fall_evt   <= 1'b0;
            if (ps2_clk_p1 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == 8'(FILTER_LEN - 1)) begin
                clk_filt <= ps2_clk_p1;
                filt_cnt <= '0;
                fall_evt <= clk_filt;
            end else begin
                filt_cnt <= filt_cnt + 8'd1;
            end
        end
    end

    // Data-line synchroniser; fall_data is aligned with fall_evt
    always_ff @(posedge CLK100MHz) begin
        ps2_data_p0 <= ps2_data;
        ps2_data_p1 <= ps2_data_p0;
        fall_data   <= ps2_data_p1;
    end

`ifdef PS2_PARITY_CHECK_EN
    assign par_ok = ^{shreg, par_bit};
`else
    assign par_ok = 1'b1;
`endif

    assign timeout = (state != IDLE) && !fall_evt && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Frame FSM state register
    always_ff @(posedge CLK100MHz) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Frame FSM next state, byte-complete and frame-error decisions
    always_comb begin
        state_n = state;
        done_c  = 1'b0;
        err_c   = 1'b0;
        case (state)
            IDLE: if (fall_evt) begin
                if (!fall_data) state_n = DATA;
                else            err_c   = 1'b1;
            end
            DATA:   if (fall_evt && bit_idx == 3'd7) state_n = PARITY;
            PARITY: if (fall_evt) state_n = STOP;
            STOP: if (fall_evt) begin
                state_n = IDLE;
                if (fall_data && par_ok) done_c = 1'b1;
                else                     err_c  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        if (timeout) begin
            state_n = IDLE;
            err_c   = 1'b1;
            done_c  = 1'b0;
        end
    end

    // Bit index and inter-edge timeout counter
    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            bit_idx <= '0;
            tmo_cnt <= '0;
        end else begin
            if (state == IDLE)                bit_idx <= '0;
            else if (state == DATA && fall_evt) bit_idx <= bit_idx + 3'd1;
            if (state == IDLE || fall_evt)    tmo_cnt <= '0;
            else                              tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Shift register, LSB first; parity bit kept only when it is checked
    always_ff @(posedge CLK100MHz) begin
        if (state == DATA && fall_evt) shreg <= {fall_data, shreg[7:1]};
`ifdef PS2_PARITY_CHECK_EN
        if (state == PARITY && fall_evt) par_bit <= fall_data;
`endif
    end

    // Frame stage -> decode stage boundary
    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            vld_p1    <= done_c;
            frame_err <= err_c;
        end
        byte_p1 <= shreg;
    end

    assign push = vld_p1 && (byte_p1 != 8'hE0) && (byte_p1 != 8'hF0);

    // Prefix flags: E0/F0 arm them, any other byte consumes them, errors clear them
    always_ff @(posedge CLK100MHz) begin
        if (reset || err_c) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else if (vld_p1) begin
            if (byte_p1 == 8'hE0) begin
                ext_flag <= 1'b1;
            end else if (byte_p1 == 8'hF0) begin
                brk_flag <= 1'b1;
            end else begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end
        end
    end

    assign full     = (count == CW'(FIFO_DEPTH));
    assign do_pop   = evt_valid && evt_ready;
    assign do_write = push && (!full || do_pop);

    // FIFO pointers, occupancy and sticky overflow; pointers wrap naturally
    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_write) - CW'(do_pop);
            if (push && full && !do_pop) overflow <= 1'b1;
        end
    end

    // FIFO storage, written with the event and the flags in force for it
    always_ff @(posedge CLK100MHz) begin
        if (do_write) mem[wr_ptr] <= {ext_flag, brk_flag, byte_p1};
    end

    // Head entry is masked to zero while empty so storage needs no reset
    assign head       = mem[rd_ptr];
    assign evt_valid  = (count != '0);
    assign evt_code   = evt_valid ? head[7:0] : 8'h00;
    assign evt_break  = evt_valid & head[8];
    assign evt_ext    = evt_valid & head[9];
    assign fifo_count = count;

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8, meaning cycles ps2_clk must hold a new level before it is accepted (range 2..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 20000, meaning max CLK100MHz cycles between falling edges inside a frame (200 us).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning event FIFO entries (power of two, 2..64).
REQ-004 SHALL have port CLK100MHz  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports ps2_clk, ps2_data  input  1 each  asynchronous PS/2 lines.
REQ-007 SHALL have port evt_valid  output  1  FIFO non-empty.
REQ-008 SHALL have port evt_ready  input  1  consumer pop request.
REQ-009 SHALL have ports evt_code (output, 8, scan code), evt_ext (output, 1, E0 prefix seen) and evt_break (output, 1, F0 prefix seen, i.e. key release), all for the FIFO head entry.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on any rejected frame.
REQ-011 SHALL have port overflow  output  1  sticky flag, event dropped because FIFO was full.
REQ-012 SHALL have port fifo_count  output  clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-013 SHALL pass ps2_clk and ps2_data through 2-flop synchronisers, then apply the FILTER_LEN stability filter to ps2_clk only.
REQ-014 SHALL generate fall_evt for exactly one cycle when the filtered clock goes 1->0, and sample synchronised ps2_data on that cycle.
REQ-015 SHALL run a frame FSM with states IDLE, DATA, PARITY, STOP.
- IDLE: fall_evt with data=0 -> DATA, bit index 0.
- IDLE: fall_evt with data=1 -> stay IDLE, frame_err pulse.
REQ-016 SHALL shift 8 bits LSB-first in DATA; after bit 7 -> PARITY; PARITY sample -> STOP.
REQ-017 SHALL, in STOP, check data=1 (and parity per REQ-027), then return to IDLE; pass = byte complete, fail = frame_err and byte discarded.
REQ-018 SHALL count cycles since the last fall_evt while not IDLE; at TIMEOUT_CYCLES -> IDLE, frame_err pulse, partial byte discarded.
REQ-019 SHALL decode completed bytes.
- 0xE0 sets ext flag; 0xF0 sets brk flag; no event for either.
- Any other byte emits event {ext, brk, code}, then clears both flags.
REQ-020 SHALL clear ext and brk on any frame_err.
REQ-021 SHALL push the event in the cycle after byte completion; evt_valid rises the cycle after the push (first-word fall-through, outputs driven from the head entry).
REQ-022 SHALL pop when evt_valid && evt_ready; evt_ready while empty has no effect.
REQ-023 SHALL, on push while full without pop, drop the event, set overflow, and leave the FIFO contents unchanged.
REQ-024 SHALL, on push while full with simultaneous pop, accept both; count unchanged; overflow not set.
REQ-025 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.
REQ-026 SHALL NOT modify evt_code/evt_ext/evt_break while evt_valid=1 and no pop occurs.

Configuration
REQ-027 SHALL gate parity checking with macro PS2_PARITY_CHECK_EN: when defined, the frame is rejected (frame_err) unless the 8 data bits plus the parity bit have odd weight; when undefined, the parity bit is sampled and ignored.

Reset
REQ-028 SHALL, while reset=1, set FSM=IDLE; clear bit index, timeout counter, ext/brk flags and FIFO pointers; and force filtered clock state=1.
REQ-029 SHALL drive evt_valid=0, evt_code=0, evt_ext=0, evt_break=0, frame_err=0, overflow=0, fifo_count=0 during and after reset until new activity.
REQ-030 SHALL, on reset asserted mid-frame, discard the partial byte; the first frame after release is accepted only from a fresh start bit.

Verification
REQ-031 SHALL cover: frame 0x1C (odd parity 0), 12.5 kHz clock -> one event code=0x1C ext=0 brk=0, fifo_count=1.
REQ-032 SHALL cover: bytes E0,F0,75 -> single event code=0x75 ext=1 brk=1; then 0x75 alone -> ext=0 brk=0.
REQ-033 SHALL cover: 0x1C with wrong parity -> frame_err one cycle, no event with the macro defined; event emitted with the macro undefined.
REQ-034 SHALL cover: clock stopped after 4 data bits for 25000 cycles -> frame_err, FSM IDLE; the next valid 0x29 frame -> event 0x29.
REQ-035 SHALL cover: FIFO_DEPTH+1 events with evt_ready=0 -> fifo_count=FIFO_DEPTH, overflow=1, popped data equals the first FIFO_DEPTH codes in order.
REQ-036 SHALL cover: 1-cycle glitch on ps2_clk with FILTER_LEN=8 -> no fall_evt and no state change.
